// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter.
package booth_pkg;
  localparam int DEF_N = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Requester, response and multiplier-side signals of the arbiter.
interface booth_mul_arbiter_if #(
  parameter int N = booth_pkg::DEF_N
);
  logic [1:0]     req;
  logic [N-1:0]   a0;
  logic [N-1:0]   b0;
  logic [N-1:0]   a1;
  logic [N-1:0]   b1;
  logic [1:0]     ack;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [2*N-1:0] rsp_product;
  logic           rsp_err;
  logic           mul_init;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic           mul_done;
  logic [2*N-1:0] mul_product;
  logic           busy;

  modport slave (
    input  req, a0, b0, a1, b1,
    input  rsp_ready, mul_done, mul_product,
    output ack, rsp_valid, rsp_product,
    output rsp_err, mul_init, mul_a, mul_b,
    output busy
  );

  modport master (
    output req, a0, b0, a1, b1,
    output rsp_ready, mul_done, mul_product,
    input  ack, rsp_valid, rsp_product,
    input  rsp_err, mul_init, mul_a, mul_b,
    input  busy
  );
endinterface

// File: rtl/booth_mul_arbiter_rr_pick2.sv
// Two-way round-robin choice: on a tie the requester
// not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id = 1'b0;
    unique case (1'b1)
      (req == 2'b11): gnt_id = ~last;
      (req == 2'b10): gnt_id = 1'b1;
      default:        gnt_id = 1'b0;
    endcase
  end
endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one external Booth multiplier between two
// requesters with round-robin arbitration and timeout.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                rst,
  booth_mul_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  state_t         state;
  state_t         state_nx;
  logic           owner;
  logic           last;
  logic           gnt_valid;
  logic           gnt_id;
  logic           expired;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   mul_a_q;
  logic [N-1:0]   mul_b_q;
  logic [2*N-1:0] prod_q;
  logic           err_q;

  rr_pick2 u_pick (
    .req       (bus.req),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign expired = (cnt == CMAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (gnt_valid) state_nx = LAUNCH;
      LAUNCH: state_nx = WAIT;
      WAIT:   if (bus.mul_done || expired) state_nx = RESP;
      RESP:   if (bus.rsp_ready[owner]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ack is Mealy so the grant and operand capture share a cycle
  always_comb begin
    bus.ack = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.mul_init = 1'b0;
    bus.busy = (state != IDLE);
    unique case (state)
      IDLE:   if (gnt_valid && !rst) bus.ack[gnt_id] = 1'b1;
      LAUNCH: bus.mul_init = 1'b1;
      RESP:   bus.rsp_valid[owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (gnt_valid) begin
          owner <= gnt_id;
          mul_a_q <= gnt_id ? bus.a1 : bus.a0;
          mul_b_q <= gnt_id ? bus.b1 : bus.b0;
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          if (bus.mul_done) begin
            prod_q <= bus.mul_product;
            err_q <= 1'b0;
          end else if (expired) begin
            prod_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (bus.rsp_ready[owner]) last <= owner;
        default: ;
      endcase
    end
  end

  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;
  assign bus.rsp_product = prod_q;
  assign bus.rsp_err = err_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: behavioural multiplier,
// scoreboard, vector table and corner sequences.
module tb_booth_mul_arbiter;
  import booth_pkg::*;

  localparam int N = 8;
  localparam int TO = 16;

  typedef struct {
    int id;
    int a;
    int b;
    int p;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] p;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  booth_mul_arbiter_if #(.N(N)) bus();

  booth_mul_arbiter #(
    .N       (N),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] p16(input int v);
    logic [31:0] r;
    r = '0;
    r[2*N-1:0] = v[2*N-1:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // behavioural multiplier: done lat cycles after mul_init
  bit model_en = 1'b1;
  bit stray = 1'b0;
  int lat = 1;
  int cd = 0;
  bit pend = 1'b0;
  int ma, mb;
  logic [2*N-1:0] mprod = '0;

  always @(negedge clk) begin
    bus.mul_done = stray;
    bus.mul_product = '1;
    if (rst || !model_en) begin
      pend = 1'b0;
    end else if (bus.mul_init) begin
      ma = $signed(bus.mul_a);
      mb = $signed(bus.mul_b);
      mprod = (2*N)'(ma * mb);
      cd = lat;
      pend = 1'b1;
    end else if (pend) begin
      cd--;
      if (cd == 0) begin
        bus.mul_done = 1'b1;
        bus.mul_product = mprod;
        pend = 1'b0;
      end
    end
  end

  // scoreboard
  exp_t q[$];
  int grants[$];
  int ack_t[$];
  logic [31:0] got[$];
  int ack_cnt[2] = '{0, 0};
  int init_cnt = 0;
  int m_a, m_b;
  exp_t m_e;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (bus.mul_init) init_cnt++;
      for (int i = 0; i < 2; i++) begin
        if (bus.ack[i]) begin
          m_a = (i == 0) ? int'($signed(bus.a0)) : int'($signed(bus.a1));
          m_b = (i == 0) ? int'($signed(bus.b0)) : int'($signed(bus.b1));
          m_e.id = i;
          m_e.p = model_en ? p16(m_a * m_b) : 32'd0;
          m_e.e = !model_en;
          q.push_back(m_e);
          grants.push_back(i);
          ack_t.push_back(cyc);
          ack_cnt[i]++;
        end
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          got.push_back(32'(bus.rsp_product));
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: response on %0d, none expected", i);
          end else begin
            m_e = q.pop_front();
            chk("sb_id", i, m_e.id);
            chk("sb_prod", 32'(bus.rsp_product), m_e.p);
            chk("sb_err", 32'(bus.rsp_err), 32'(m_e.e));
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.rsp_ready = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue(input int id, input int a, input int b,
                       output int t_ack);
    @(posedge clk);
    #1;
    if (id == 0) begin
      bus.a0 = N'(a);
      bus.b0 = N'(b);
    end else begin
      bus.a1 = N'(a);
      bus.b1 = N'(b);
    end
    bus.req[id] = 1'b1;
    t_ack = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ack[id]) begin
        t_ack = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req[id] = 1'b0;
    if (t_ack < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack for requester %0d", id);
    end
  endtask

  task automatic wait_rsp(input int id, input int budget, output int t_v);
    t_v = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.rsp_valid[id]) begin
        t_v = cyc;
        break;
      end
    end
    if (t_v < 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: no rsp_valid for requester %0d", id);
    end
  endtask

  task automatic accept(input int id);
    @(posedge clk);
    #1;
    bus.rsp_ready[id] = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int ta, tv, i0, a0c, viol;

    tbl[0] = '{0, 0, 55, 0};
    tbl[1] = '{1, -128, -128, 16384};
    tbl[2] = '{0, -128, 127, -16256};
    tbl[3] = '{1, 127, 127, 16129};
    tbl[4] = '{0, -1, -1, 1};
    tbl[5] = '{1, -7, 9, -63};
    tbl[6] = '{0, 1, -128, -128};

    bus.req = 2'b00;
    bus.a0 = '0;
    bus.b0 = '0;
    bus.a1 = '0;
    bus.b1 = '0;
    bus.rsp_ready = 2'b00;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_product", bus.rsp_product, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mul_init", bus.mul_init, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single request, 10-cycle multiplier
    lat = 10;
    i0 = init_cnt;
    a0c = ack_cnt[0];
    issue(0, 7, -3, ta);
    @(negedge clk);
    chk("launch_init", bus.mul_init, 1);
    chk("launch_a", bus.mul_a, 8'h07);
    chk("launch_b", bus.mul_b, 8'hFD);
    wait_rsp(0, 30, tv);
    chk("lat10", tv - ta, 12);
    chk("single_prod", bus.rsp_product, p16(-21));
    chk("single_err", bus.rsp_err, 0);
    chk("single_valid", bus.rsp_valid, 2'b01);
    repeat (2) @(negedge clk);
    chk("single_valid_held", bus.rsp_valid, 2'b01);
    accept(0);
    chk("single_one_init", init_cnt - i0, 1);
    chk("single_one_ack", ack_cnt[0] - a0c, 1);

    // vector table at minimum latency
    lat = 1;
    for (int k = 0; k < 7; k++) begin
      issue(tbl[k].id, tbl[k].a, tbl[k].b, ta);
      wait_rsp(tbl[k].id, 10, tv);
      chk("vec_lat", tv - ta, 3);
      chk("vec_prod", bus.rsp_product, p16(tbl[k].p));
      chk("vec_err", bus.rsp_err, 0);
      accept(tbl[k].id);
    end

    // timeout, then normal service
    model_en = 1'b0;
    issue(0, 5, 6, ta);
    wait_rsp(0, TO + 10, tv);
    chk("to_lat", tv - ta, TO + 2);
    chk("to_prod", bus.rsp_product, 0);
    chk("to_err", bus.rsp_err, 1);
    accept(0);
    model_en = 1'b1;
    issue(1, 3, -4, ta);
    wait_rsp(1, 10, tv);
    chk("after_to_prod", bus.rsp_product, p16(-12));
    chk("after_to_err", bus.rsp_err, 0);
    accept(1);

    // response held while owner not ready; other ready ignored
    issue(0, -5, 11, ta);
    wait_rsp(0, 10, tv);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus.rsp_ready[1] = (k % 2 == 0);
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 2'b01);
      chk("hold_prod", bus.rsp_product, p16(-55));
    end
    bus.rsp_ready[1] = 1'b0;
    accept(0);

    // tie from reset, then alternation
    do_reset();
    grants.delete();
    ack_t.delete();
    got.delete();
    @(posedge clk);
    #1;
    bus.a0 = 8'd2;
    bus.b0 = 8'd3;
    bus.a1 = 8'd4;
    bus.b1 = 8'd5;
    bus.rsp_ready = 2'b11;
    bus.req = 2'b11;
    for (int k = 0; k < 60 && grants.size() < 4; k++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.req = 2'b00;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 2'b00;
    chk("tie_grant_count", grants.size(), 4);
    chk("tie_rsp_count", got.size(), 4);
    if (grants.size() >= 4 && got.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("tie_grant", grants[k], k % 2);
        chk("tie_prod", got[k], (k % 2) ? p16(20) : p16(6));
      end
      for (int k = 0; k < 3; k++) chk("tie_gap", ack_t[k+1] - ack_t[k], 4);
    end

    // reset during WAIT, then a stray done
    lat = 10;
    issue(1, 9, 9, ta);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ack", bus.ack, 0);
    chk("abort_valid", bus.rsp_valid, 0);
    chk("abort_init", bus.mul_init, 0);
    chk("abort_mul_a", bus.mul_a, 0);
    chk("abort_mul_b", bus.mul_b, 0);
    chk("abort_prod", bus.rsp_product, 0);
    chk("abort_err", bus.rsp_err, 0);
    @(posedge clk);
    #1;
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00 || bus.mul_init || bus.busy) viol++;
    end
    chk("late_done_quiet", viol, 0);
    chk("sb_flushed", q.size(), 0);
    lat = 1;
    issue(1, -3, -3, ta);
    wait_rsp(1, 10, tv);
    chk("recover_prod", bus.rsp_product, p16(9));
    accept(1);

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter N, default 8, operand width in bits.
REQ-002 Parameter TIMEOUT, default 64, maximum cycles to wait for mul_done.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester request; held high until the matching ack.
REQ-006 a0, b0  input  N  requester 0 signed multiplicand and multiplier.
REQ-007 a1, b1  input  N  requester 1 signed multiplicand and multiplier.
REQ-008 ack  output  2  one-cycle pulse; operands of that requester captured this cycle.
REQ-009 rsp_valid  output  2  result valid for requester i; held until rsp_ready[i].
REQ-010 rsp_ready  input  2  requester i accepts the result.
REQ-011 rsp_product  output  2N  signed product for the current owner.
REQ-012 rsp_err  output  1  the current response is a timeout, not a product.
REQ-013 mul_init  output  1  start pulse to the shared Booth multiplier.
REQ-014 mul_a, mul_b  output  N  registered operands driven to the multiplier.
REQ-015 mul_done  input  1  multiplier completion pulse.
REQ-016 mul_product  input  2N  multiplier result; valid in the mul_done cycle.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL use four states: IDLE, LAUNCH, WAIT, RESP.
REQ-019 In IDLE, with any req bit set, the block SHALL pick the owner, capture that owner's a/b into mul_a/mul_b, pulse ack[owner], and enter LAUNCH on the next edge.
REQ-020 Arbitration SHALL be round-robin: if both requests are high, the owner is the requester not served last. The last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-021 In LAUNCH, mul_init SHALL be 1 for exactly one cycle; the next state SHALL be WAIT.
REQ-022 In WAIT:
- mul_done=1: capture mul_product into rsp_product, clear rsp_err, enter RESP.
- Otherwise: increment the wait counter.
- Counter reaches TIMEOUT-1 without mul_done: set rsp_err=1, set rsp_product=0, enter RESP.
REQ-023 mul_done SHALL be ignored in IDLE, LAUNCH and RESP.
REQ-024 In RESP, rsp_valid[owner] SHALL be 1 and rsp_valid[other] SHALL be 0.
REQ-025 In RESP, on rsp_ready[owner]=1, the block SHALL update the last-served pointer to owner and return to IDLE; rsp_ready[other] SHALL be ignored.
REQ-026 rsp_product, rsp_err and mul_a/mul_b SHALL remain stable from capture until the next capture.
REQ-027 Minimum latency from ack to rsp_valid SHALL be 3 cycles (LAUNCH, WAIT with mul_done, RESP).
REQ-028 A new request SHALL NOT be accepted in the cycle the block leaves RESP; acceptance occurs in the following IDLE cycle. The throughput gap is 1 cycle.
REQ-029 A req deasserted before ack SHALL be dropped without side effects.
REQ-030 The wait counter SHALL be ceil(log2(TIMEOUT)) bits wide, clear on LAUNCH, and never wrap.

Reset
REQ-031 On rst, the block SHALL enter IDLE and clear:
- outputs: ack, rsp_valid, rsp_product, rsp_err, mul_init, mul_a, mul_b, busy;
- internal: wait counter.
The last-served pointer SHALL be set to 1.
REQ-032 rst asserted mid-transaction SHALL abandon it: no ack, no rsp_valid, and no mul_init after the reset edge. The caller resets the multiplier on the same rst.

Structure
REQ-033 A shared package booth_pkg SHALL hold the state enum, the default N and the default TIMEOUT.
REQ-034 A sub-module rr_pick2 SHALL implement the two-way round-robin choice:
- inputs: req[1:0], last;
- outputs: gnt_valid, gnt_id.
REQ-035 The multiplier SHALL be instantiated outside this block.

Verification
REQ-036 Single request, a0=7, b0=-3, behavioural model returns done 10 cycles after init -> ack[0] one cycle, one mul_init pulse, rsp_product=-21, rsp_err=0, rsp_valid[0] until rsp_ready[0].
REQ-037 Both req high from reset, a0=2, b0=3, a1=4, b1=5 -> requester 0 served first (6), then requester 1 (20), each with ack exactly once.
REQ-038 Both req held high for 4 transactions -> grants alternate 0,1,0,1.
REQ-039 Model never asserts mul_done -> rsp_err=1 and rsp_product=0 after TIMEOUT WAIT cycles; the next request is served normally.
REQ-040 rsp_ready[0] held low 5 cycles in RESP -> rsp_valid[0] and rsp_product stable; rsp_ready[1] pulses ignored.
REQ-041 rst pulsed during WAIT -> busy=0 and all outputs zero next cycle; a late mul_done produces no response.
